dsp_file_server: RTL and testbench

- Responder side of the DSP equation-engine file interface.
- Holds NUM_FILES circular sample buffers ("files") in one synchronous memory. Serves single-word read and write requests from one equation engine using the file_read/file_write/file_active handshake.
- Reports rd_ptr/wr_ptr of the currently selected file so the engine can detect end-of-data.
- A host port preloads input files and clears files between equations.

---
 rtl/dsp_file_server.sv | 159 +++++++++++++++
 tb/tb_dsp_file_server.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_file_server.sv
// Responder for the equation-engine file interface: NUM_FILES circular sample
// buffers in one synchronous memory, an engine handshake port and a host preload/clear port.
module dsp_file_server #(
  parameter int dw         = 32,
  parameter int NUM_FILES  = 4,
  parameter int FILE_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic [7:0]           file_num,
  input  logic                 file_read,
  input  logic                 file_write,
  input  logic [dw-1:0]        file_write_data,
  output logic [dw-1:0]        file_read_data,
  output logic                 file_active,
  output logic [31:0]          rd_ptr,
  output logic [31:0]          wr_ptr,
  input  logic                 host_we,
  input  logic                 host_clear,
  input  logic [7:0]           host_file,
  input  logic [dw-1:0]        host_data,
  output logic                 host_ready,
  output logic                 error,
  output logic [NUM_FILES-1:0] file_empty,
  output logic [NUM_FILES-1:0] file_full
);

  localparam int FW = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FILE_DEPTH);

  // Engine handshake: a request level seen in IDLE starts one transaction;
  // file_active stays high for ACCESS and DATA, then RELEASE waits for both
  // request levels to drop so a held level never triggers a second access.
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DATA, S_RELEASE} state_t;

  state_t        r_state;
  logic [7:0]    r_file;
  logic          r_is_rd;
  logic [AW-1:0] r_rd  [NUM_FILES];
  logic [AW-1:0] r_wr  [NUM_FILES];
  logic [AW:0]   r_cnt [NUM_FILES];
  logic [dw-1:0] r_mem [NUM_FILES*FILE_DEPTH];

  logic [FW-1:0]    w_sel_f, w_eng_f, w_host_f;
  logic             w_sel_valid, w_eng_valid, w_host_valid;
  logic             w_eng_req, w_eng_rd_ok, w_eng_wr_ok, w_host_wr_ok;
  logic             w_eng_go_wr, w_host_go_wr, w_mem_we;
  logic [FW+AW-1:0] w_mem_addr, w_rd_addr;
  logic [dw-1:0]    w_mem_wdata;

  assign w_sel_f      = file_num[FW-1:0];
  assign w_eng_f      = r_file[FW-1:0];
  assign w_host_f     = host_file[FW-1:0];
  assign w_sel_valid  = 32'(file_num) < NUM_FILES;
  assign w_eng_valid  = 32'(r_file) < NUM_FILES;
  assign w_host_valid = 32'(host_file) < NUM_FILES;
  assign w_eng_req    = file_read | file_write;
  assign w_eng_rd_ok  = w_eng_valid && (r_cnt[w_eng_f] != '0);
  assign w_eng_wr_ok  = w_eng_valid && (r_cnt[w_eng_f] != FULL_CNT);
  assign w_host_wr_ok = w_host_valid && (r_cnt[w_host_f] != FULL_CNT);

  // Host and engine writes never coincide: the host is only served in IDLE.
  assign w_eng_go_wr  = (r_state == S_ACCESS) && !r_is_rd && w_eng_wr_ok;
  assign w_host_go_wr = (r_state == S_IDLE) && !w_eng_req && !host_clear && host_we && w_host_wr_ok;
  assign w_mem_we     = !wb_rst && (w_eng_go_wr || w_host_go_wr);
  assign w_mem_addr   = w_eng_go_wr ? {w_eng_f, r_wr[w_eng_f]} : {w_host_f, r_wr[w_host_f]};
  assign w_mem_wdata  = w_eng_go_wr ? file_write_data : host_data;
  assign w_rd_addr    = {w_eng_f, r_rd[w_eng_f]};

  always_ff @(posedge wb_clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_comb begin
    file_empty = '0;
    file_full  = '0;
    for (int i = 0; i < NUM_FILES; i++) begin
      file_empty[i] = (r_cnt[i] == '0);
      file_full[i]  = (r_cnt[i] == FULL_CNT);
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state        <= S_IDLE;
      r_file         <= '0;
      r_is_rd        <= 1'b0;
      file_active    <= 1'b0;
      file_read_data <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      error          <= 1'b0;
      host_ready     <= 1'b0;
      for (int i = 0; i < NUM_FILES; i++) begin
        r_rd[i]  <= '0;
        r_wr[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      host_ready <= 1'b0;
      rd_ptr     <= w_sel_valid ? {{(32-AW){1'b0}}, r_rd[w_sel_f]} : '0;
      wr_ptr     <= w_sel_valid ? {{(32-AW){1'b0}}, r_wr[w_sel_f]} : '0;
      case (r_state)
        S_IDLE: begin
          if (w_eng_req) begin
            r_file      <= file_num;
            r_is_rd     <= file_read;
            file_active <= 1'b1;
            r_state     <= S_ACCESS;
            if (file_read && file_write) error <= 1'b1;
          end else if (host_clear) begin
            host_ready <= 1'b1;
            error      <= 1'b0;
            if (w_host_valid) begin
              r_rd[w_host_f]  <= '0;
              r_wr[w_host_f]  <= '0;
              r_cnt[w_host_f] <= '0;
            end
          end else if (host_we) begin
            host_ready <= 1'b1;
            if (w_host_wr_ok) begin
              r_wr[w_host_f]  <= r_wr[w_host_f] + AW'(1);
              r_cnt[w_host_f] <= r_cnt[w_host_f] + (AW+1)'(1);
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          r_state <= S_DATA;
          if (r_is_rd) begin
            if (w_eng_rd_ok) begin
              file_read_data <= r_mem[w_rd_addr];
              r_rd[w_eng_f]  <= r_rd[w_eng_f] + AW'(1);
              r_cnt[w_eng_f] <= r_cnt[w_eng_f] - (AW+1)'(1);
            end else begin
              file_read_data <= '0;
              error          <= 1'b1;
            end
          end else if (w_eng_wr_ok) begin
            r_wr[w_eng_f]  <= r_wr[w_eng_f] + AW'(1);
            r_cnt[w_eng_f] <= r_cnt[w_eng_f] + (AW+1)'(1);
          end else begin
            error <= 1'b1;
          end
        end
        S_DATA: begin
          file_active <= 1'b0;
          r_state     <= S_RELEASE;
        end
        default: begin
          if (!w_eng_req) r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_file_server.sv
// Directed bench for dsp_file_server: host preload/clear, engine read/write
// handshakes, full/empty boundaries, held request levels and mid-access reset.
module tb_dsp_file_server;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [7:0]  file_num = '0;
  logic        file_read = 1'b0;
  logic        file_write = 1'b0;
  logic [31:0] file_write_data = '0;
  logic [31:0] file_read_data;
  logic        file_active;
  logic [31:0] rd_ptr, wr_ptr;
  logic        host_we = 1'b0;
  logic        host_clear = 1'b0;
  logic [7:0]  host_file = '0;
  logic [31:0] host_data = '0;
  logic        host_ready;
  logic        error;
  logic [3:0]  file_empty, file_full;

  dsp_file_server dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .file_num(file_num), .file_read(file_read), .file_write(file_write),
    .file_write_data(file_write_data), .file_read_data(file_read_data),
    .file_active(file_active), .rd_ptr(rd_ptr), .wr_ptr(wr_ptr),
    .host_we(host_we), .host_clear(host_clear), .host_file(host_file),
    .host_data(host_data), .host_ready(host_ready), .error(error),
    .file_empty(file_empty), .file_full(file_full)
  );

  always #5 wb_clk = ~wb_clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rdata;
  int          act, rdy_seen;
  logic        got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One engine transaction; returns the data sampled on the last active cycle.
  task automatic eng_op(input logic is_rd, input logic [7:0] f, input logic [31:0] wd,
                        output logic [31:0] rd_o, output int act_o);
    act_o = 0;
    rd_o = '0;
    file_num = f;
    file_write_data = wd;
    file_read = is_rd;
    file_write = !is_rd;
    for (int k = 0; k < 10; k++) begin
      @(posedge wb_clk); #1;
      if (file_active) begin
        act_o++;
        rd_o = file_read_data;
      end else if (act_o > 0) begin
        break;
      end
    end
    file_read = 1'b0;
    file_write = 1'b0;
    @(posedge wb_clk); #1;
    if (act_o == 0) check("eng_timeout", 32'd0, 32'd1);
  endtask

  task automatic host_op(input logic we, input logic clr, input logic [7:0] f, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    host_we = we;
    host_clear = clr;
    host_file = f;
    host_data = d;
    for (int k = 0; k < 20; k++) begin
      @(posedge wb_clk); #1;
      if (host_ready) begin
        ok = 1'b1;
        break;
      end
    end
    host_we = 1'b0;
    host_clear = 1'b0;
    check("host_ready", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst_active", {31'd0, file_active}, 32'd0);
    check("rst_rdata", file_read_data, 32'd0);
    check("rst_rd_ptr", rd_ptr, 32'd0);
    check("rst_wr_ptr", wr_ptr, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_host_ready", {31'd0, host_ready}, 32'd0);
    check("rst_empty", {28'd0, file_empty}, 32'hF);
    check("rst_full", {28'd0, file_full}, 32'h0);
    wb_rst = 1'b0;
    @(posedge wb_clk); #1;

    // host preload 3,5,7 into file 0, engine reads them back
    host_op(1'b1, 1'b0, 8'd0, 32'd3);
    host_op(1'b1, 1'b0, 8'd0, 32'd5);
    host_op(1'b1, 1'b0, 8'd0, 32'd7);
    check("f0_not_empty", {31'd0, file_empty[0]}, 32'd0);
    eng_op(1'b1, 8'd0, '0, rdata, act);
    check("rd0_data", rdata, 32'd3);
    check("rd0_active", act, 32'd2);
    check("rd0_rd_ptr", rd_ptr, 32'd1);
    eng_op(1'b1, 8'd0, '0, rdata, act);
    check("rd1_data", rdata, 32'd5);
    check("rd1_active", act, 32'd2);
    check("rd1_rd_ptr", rd_ptr, 32'd2);
    eng_op(1'b1, 8'd0, '0, rdata, act);
    check("rd2_data", rdata, 32'd7);
    check("rd2_active", act, 32'd2);
    check("rd2_rd_ptr", rd_ptr, 32'd3);
    check("f0_empty", {31'd0, file_empty[0]}, 32'd1);
    check("no_error", {31'd0, error}, 32'd0);

    // engine write to file 2, read it back
    file_num = 8'd2;
    @(posedge wb_clk); #1;
    check("f2_wr_ptr0", wr_ptr, 32'd0);
    eng_op(1'b0, 8'd2, 32'h1234, rdata, act);
    check("wr_active", act, 32'd2);
    check("f2_wr_ptr1", wr_ptr, 32'd1);
    check("f2_not_empty", {31'd0, file_empty[2]}, 32'd0);
    eng_op(1'b1, 8'd2, '0, rdata, act);
    check("f2_rdata", rdata, 32'h0000_1234);

    // fill file 1, overflow write must be dropped
    file_num = 8'd1;
    for (int i = 0; i < 16; i++) begin
      host_op(1'b1, 1'b0, 8'd1, 32'h100 + i);
      exp_q.push_back(32'h100 + i);
      if (i == 14) begin
        @(posedge wb_clk); #1;
        check("f1_wr_ptr15", wr_ptr, 32'd15);
        check("f1_not_full", {31'd0, file_full[1]}, 32'd0);
      end
    end
    check("f1_full", {31'd0, file_full[1]}, 32'd1);
    check("fill_no_error", {31'd0, error}, 32'd0);
    eng_op(1'b0, 8'd1, 32'hDEAD, rdata, act);
    check("ovf_error", {31'd0, error}, 32'd1);
    check("ovf_still_full", {31'd0, file_full[1]}, 32'd1);
    check("ovf_wr_ptr", wr_ptr, 32'd0);
    for (int i = 0; i < 16; i++) begin
      eng_op(1'b1, 8'd1, '0, rdata, act);
      check("drain_data", rdata, exp_q.pop_front());
    end
    check("f1_empty", {31'd0, file_empty[1]}, 32'd1);
    check("f1_rd_ptr_wrap", rd_ptr, 32'd0);

    // empty read on file 3
    host_op(1'b0, 1'b1, 8'd3, '0);
    check("clr_error", {31'd0, error}, 32'd0);
    eng_op(1'b1, 8'd3, '0, rdata, act);
    check("empty_rdata", rdata, 32'd0);
    check("empty_active", act, 32'd2);
    check("empty_error", {31'd0, error}, 32'd1);
    check("empty_rd_ptr", rd_ptr, 32'd0);
    host_op(1'b0, 1'b1, 8'd3, '0);
    check("clr3_error", {31'd0, error}, 32'd0);

    // held read level plus a waiting host write
    host_op(1'b1, 1'b0, 8'd0, 32'hAA);
    host_op(1'b1, 1'b0, 8'd0, 32'hBB);
    file_num = 8'd0;
    file_read = 1'b1;
    host_we = 1'b1;
    host_file = 8'd0;
    host_data = 32'hCC;
    act = 0;
    rdy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge wb_clk); #1;
      if (file_active) begin
        act++;
        rdata = file_read_data;
      end
      if (host_ready) rdy_seen++;
    end
    file_read = 1'b0;
    check("hold_active", act, 32'd2);
    check("hold_rdata", rdata, 32'hAA);
    check("hold_host_blocked", rdy_seen, 32'd0);
    check("hold_rd_ptr", rd_ptr, 32'd4);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge wb_clk); #1;
      if (host_ready) begin
        got = 1'b1;
        break;
      end
    end
    host_we = 1'b0;
    check("hold_host_served", {31'd0, got}, 32'd1);
    eng_op(1'b1, 8'd0, '0, rdata, act);
    check("after_hold_bb", rdata, 32'hBB);
    eng_op(1'b1, 8'd0, '0, rdata, act);
    check("after_hold_cc", rdata, 32'hCC);

    // out-of-range file
    eng_op(1'b1, 8'd9, '0, rdata, act);
    check("oor_rdata", rdata, 32'd0);
    check("oor_active", act, 32'd2);
    check("oor_error", {31'd0, error}, 32'd1);
    check("oor_rd_ptr", rd_ptr, 32'd0);

    // reset during ACCESS of a write
    file_num = 8'd2;
    @(posedge wb_clk); #1;
    check("pre_rst_wr_ptr", wr_ptr, 32'd1);
    file_write_data = 32'h5555;
    file_write = 1'b1;
    @(posedge wb_clk); #1;
    check("pre_rst_active", {31'd0, file_active}, 32'd1);
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    check("mid_rst_active", {31'd0, file_active}, 32'd0);
    check("mid_rst_wr_ptr", wr_ptr, 32'd0);
    check("mid_rst_error", {31'd0, error}, 32'd0);
    file_write = 1'b0;
    wb_rst = 1'b0;
    @(posedge wb_clk); #1;
    check("post_rst_empty", {28'd0, file_empty}, 32'hF);
    check("post_rst_full", {28'd0, file_full}, 32'h0);
    check("post_rst_wr_ptr", wr_ptr, 32'd0);
    check("post_rst_rd_ptr", rd_ptr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
